// File: rtl/frame_row_fetch_if.sv
// Request, frame_ram read port and bit-plane column bus for frame_row_fetch.
// ovf_out is present only when FRAME_ROW_FETCH_OVF_EN is defined.
interface frame_row_fetch_if #(
   parameter int unsigned NUM_ROWS = 32,
   parameter int unsigned NUM_COLS = 64,
   parameter int unsigned BIT_W    = 8
);
   localparam int unsigned ROW_W   = $clog2(NUM_ROWS / 2);
   localparam int unsigned PLANE_W = $clog2(BIT_W);

   logic                     start_in;
   logic [ROW_W-1:0]         row_in;
   logic [PLANE_W-1:0]       plane_in;
   logic                     ram_en_out;
   logic [15:0]              ram_addr_out;
   logic [23:0]              ram_data_in;
   logic [2:0][NUM_COLS-1:0] col_top_out;
   logic [2:0][NUM_COLS-1:0] col_bot_out;
   logic                     busy_out;
   logic                     done_out;
`ifdef FRAME_ROW_FETCH_OVF_EN
   logic                     ovf_out;
`endif

   modport master (
      input  start_in,
      input  row_in,
      input  plane_in,
      input  ram_data_in,
      output ram_en_out,
      output ram_addr_out,
      output col_top_out,
      output col_bot_out,
      output busy_out,
`ifdef FRAME_ROW_FETCH_OVF_EN
      output ovf_out,
`endif
      output done_out
   );

   modport slave (
      output start_in,
      output row_in,
      output plane_in,
      output ram_data_in,
      input  ram_en_out,
      input  ram_addr_out,
      input  col_top_out,
      input  col_bot_out,
      input  busy_out,
`ifdef FRAME_ROW_FETCH_OVF_EN
      input  ovf_out,
`endif
      input  done_out
   );
endinterface

// File: rtl/frame_row_fetch.sv
// Fetches one top/bottom row pair from frame_ram and slices one bit-plane per colour channel.
// Define FRAME_ROW_FETCH_OVF_EN to add a sticky ovf_out flag for starts ignored while busy.
module frame_row_fetch #(
   parameter int unsigned NUM_ROWS = 32,
   parameter int unsigned NUM_COLS = 64,
   parameter int unsigned BIT_W    = 8
) (
   input logic               clk_in,
   input logic               reset_in,
   frame_row_fetch_if.master bus
);
   localparam int unsigned HALF_ROWS = NUM_ROWS / 2;
   localparam int unsigned ROW_W     = $clog2(HALF_ROWS);
   localparam int unsigned PLANE_W   = $clog2(BIT_W);
   localparam int unsigned COL_W     = $clog2(NUM_COLS);
   localparam int unsigned CNT_W     = $clog2(2 * NUM_COLS + 1);
   localparam logic [CNT_W-1:0] RD_COUNT = CNT_W'(2 * NUM_COLS);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   typedef enum logic [1:0] {StIdle, StFetch, StDrain, StDone} state_t;

   state_t                   state_q;
   logic [CNT_W-1:0]         cnt_q;
   logic [ROW_W-1:0]         row_q;
   logic [PLANE_W-1:0]       plane_q;
   logic [COL_W-1:0]         rd_col_q;
   logic                     rd_half_q;
   logic [COL_W-1:0]         cap_col_q;
   logic                     cap_half_q;
   logic                     cap_v_q;
   logic                     ram_en_q;
   logic [15:0]              ram_addr_q;
   logic                     busy_q;
   logic                     done_q;
   logic [2:0][NUM_COLS-1:0] sh_top_q;
   logic [2:0][NUM_COLS-1:0] sh_bot_q;
   logic [2:0][NUM_COLS-1:0] col_top_q;
   logic [2:0][NUM_COLS-1:0] col_bot_q;

   logic [COL_W-1:0] iss_col;
   logic             iss_half;
   logic [15:0]      iss_addr;
   logic [7:0]       r_ch;
   logic [7:0]       g_ch;
   logic [7:0]       b_ch;

   // Reads alternate top/bottom, so bit 0 of the count selects the half.
   assign iss_col  = cnt_q[COL_W:1];
   assign iss_half = cnt_q[0];
   assign iss_addr = (16'(row_q) + (iss_half ? 16'(HALF_ROWS) : 16'd0)) * 16'(NUM_COLS)
                     + 16'(iss_col);

   assign r_ch = bus.ram_data_in[23:16];
   assign g_ch = bus.ram_data_in[15:8];
   assign b_ch = bus.ram_data_in[7:0];

   always_ff @(posedge clk_in or posedge reset_in) begin
      if (reset_in) begin
         state_q    <= StIdle;
         cnt_q      <= '0;
         row_q      <= '0;
         plane_q    <= '0;
         rd_col_q   <= '0;
         rd_half_q  <= 1'b0;
         ram_en_q   <= 1'b0;
         ram_addr_q <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         col_top_q  <= '0;
         col_bot_q  <= '0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (bus.start_in) begin
                  row_q   <= bus.row_in;
                  plane_q <= bus.plane_in;
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= StFetch;
               end
            end
            StFetch: begin
               if (cnt_q == RD_COUNT) begin
                  ram_en_q   <= 1'b0;
                  ram_addr_q <= '0;
                  cnt_q      <= '0;
                  state_q    <= StDrain;
               end else begin
                  ram_en_q   <= 1'b1;
                  ram_addr_q <= iss_addr;
                  rd_col_q   <= iss_col;
                  rd_half_q  <= iss_half;
                  cnt_q      <= cnt_q + CNT_ONE;
               end
            end
            StDrain: begin
               cnt_q <= cnt_q + CNT_ONE;
               // Last read lands in the shadow one edge before this publish.
               if (cnt_q == CNT_ONE) begin
                  col_top_q <= sh_top_q;
                  col_bot_q <= sh_bot_q;
                  done_q    <= 1'b1;
                  state_q   <= StDone;
               end
            end
            StDone: begin
               cnt_q   <= '0;
               busy_q  <= 1'b0;
               state_q <= StIdle;
            end
         endcase
      end
   end

   // Read data arrives two edges after its address; the tag rides along one stage behind.
   always_ff @(posedge clk_in or posedge reset_in) begin
      if (reset_in) begin
         cap_v_q    <= 1'b0;
         cap_col_q  <= '0;
         cap_half_q <= 1'b0;
         sh_top_q   <= '0;
         sh_bot_q   <= '0;
      end else begin
         cap_v_q    <= ram_en_q;
         cap_col_q  <= rd_col_q;
         cap_half_q <= rd_half_q;
         if (cap_v_q) begin
            if (cap_half_q) begin
               sh_bot_q[2][cap_col_q] <= r_ch[plane_q];
               sh_bot_q[1][cap_col_q] <= g_ch[plane_q];
               sh_bot_q[0][cap_col_q] <= b_ch[plane_q];
            end else begin
               sh_top_q[2][cap_col_q] <= r_ch[plane_q];
               sh_top_q[1][cap_col_q] <= g_ch[plane_q];
               sh_top_q[0][cap_col_q] <= b_ch[plane_q];
            end
         end
      end
   end

`ifdef FRAME_ROW_FETCH_OVF_EN
   logic ovf_q;

   always_ff @(posedge clk_in or posedge reset_in) begin
      if (reset_in) begin
         ovf_q <= 1'b0;
      end else if (bus.start_in && busy_q) begin
         ovf_q <= 1'b1;
      end
   end

   assign bus.ovf_out = ovf_q;
`endif

   assign bus.ram_en_out   = ram_en_q;
   assign bus.ram_addr_out = ram_addr_q;
   assign bus.col_top_out  = col_top_q;
   assign bus.col_bot_out  = col_bot_q;
   assign bus.busy_out     = busy_q;
   assign bus.done_out     = done_q;
endmodule
